// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the IF/ID and ID/EX hazard controller.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [4:0] ZERO_REG = 5'd0;

  // Controller states; the encoding is fixed so debug traces stay readable.
  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } state_t;

  // Action chosen for the current cycle; drives both output decode and next state.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_NORMAL,
    ACT_STALL,
    ACT_BRANCH,
    ACT_FLUSH,
    ACT_FREEZE
  } action_t;

  // Pipeline register controls, grouped so each action maps to one constant.
  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_HOLD   = ctrl_t'(6'b000111);
  localparam ctrl_t CTRL_NORMAL = ctrl_t'(6'b101010);
  localparam ctrl_t CTRL_STALL  = ctrl_t'(6'b000011);
  localparam ctrl_t CTRL_BRANCH = ctrl_t'(6'b111111);
  localparam ctrl_t CTRL_FLUSH  = ctrl_t'(6'b101110);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(6'b000000);

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard inputs from the ID/EX/MEM stages and the register controls returned to them.
interface hazard_ctrl_if #(
  parameter int REG_W = hazard_ctrl_pkg::REG_W
);

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             branch_taken;
  logic             mem_busy;

  logic             pc_write;
  logic             pc_src;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;

  // Pipeline side: reports hazards, obeys the controls.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
    input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
    output pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush
  );

endinterface

// File: rtl/hazard_ctrl_detect.sv
// Load-use detector: the load in EX writes a register the instruction in ID reads.
// Register zero never carries a dependency.
module hazard_ctrl_detect #(
  parameter int REG_W = hazard_ctrl_pkg::REG_W
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             load_use
);
  import hazard_ctrl_pkg::*;

  // rs is always a source; rt only when the ID instruction actually reads it.
  always_comb begin
    load_use = ex_mem_read
             & (ex_rt != REG_W'(ZERO_REG))
             & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Sequencing controller for the PC, IF/ID and ID/EX registers of the 5-stage core.
// Handles load-use bubbles, taken-branch flushes and memory-busy freezes.
// Define HAZARD_STATS_EN to add saturating stall/flush/freeze event counters.
module hazard_ctrl #(
  parameter int REG_W          = hazard_ctrl_pkg::REG_W,
  parameter int BRANCH_PENALTY = 2
) (
  input  logic         clock,
  input  logic         reset,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]  stall_cnt,
  output logic [31:0]  flush_cnt_tot,
  output logic [31:0]  freeze_cnt
`endif
);
  import hazard_ctrl_pkg::*;

  // The branch detect cycle is itself a flush cycle, so FLUSH covers the rest.
  localparam logic [2:0] PENALTY_M1 = 3'(BRANCH_PENALTY - 1);

  state_t     state;
  logic [2:0] flush_cnt;
  logic       br_pend;
  logic       load_use;
  action_t    act;
  ctrl_t      ctrl;

  hazard_ctrl_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .load_use    (load_use)
  );

  // Pick this cycle's action. Leaving FREEZE, a branch caught at freeze entry wins,
  // then any unfinished flush resumes, then ID is re-checked for a load-use.
  // A live branch_taken on that release cycle is not acted on: EX was frozen,
  // so a real branch there was already captured in br_pend.
  always_comb begin
    act = ACT_NORMAL;
    unique case (state)
      HOLD: act = ACT_HOLD;
      RUN: begin
        if (bus.mem_busy)          act = ACT_FREEZE;
        else if (bus.branch_taken) act = ACT_BRANCH;
        else if (load_use)         act = ACT_STALL;
        else                       act = ACT_NORMAL;
      end
      FLUSH: begin
        if (bus.mem_busy) act = ACT_FREEZE;
        else              act = ACT_FLUSH;
      end
      FREEZE: begin
        if (bus.mem_busy)        act = ACT_FREEZE;
        else if (br_pend)        act = ACT_BRANCH;
        else if (flush_cnt != 0) act = ACT_FLUSH;
        else if (load_use)       act = ACT_STALL;
        else                     act = ACT_NORMAL;
      end
      default: act = ACT_HOLD;
    endcase
  end

  // Decode the action into the register controls.
  always_comb begin
    ctrl = CTRL_HOLD;
    unique case (act)
      ACT_HOLD:   ctrl = CTRL_HOLD;
      ACT_NORMAL: ctrl = CTRL_NORMAL;
      ACT_STALL:  ctrl = CTRL_STALL;
      ACT_BRANCH: ctrl = CTRL_BRANCH;
      ACT_FLUSH:  ctrl = CTRL_FLUSH;
      ACT_FREEZE: ctrl = CTRL_FREEZE;
      default:    ctrl = CTRL_HOLD;
    endcase
  end

  assign bus.pc_write    = ctrl.pc_write;
  assign bus.pc_src      = ctrl.pc_src;
  assign bus.if_id_write = ctrl.if_id_write;
  assign bus.if_id_flush = ctrl.if_id_flush;
  assign bus.id_ex_write = ctrl.id_ex_write;
  assign bus.id_ex_flush = ctrl.id_ex_flush;

  // State, remaining flush count and pending-branch flag advance with the action.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= HOLD;
      flush_cnt <= 3'd0;
      br_pend   <= 1'b0;
    end else begin
      unique case (act)
        ACT_HOLD, ACT_NORMAL, ACT_STALL: state <= RUN;
        ACT_BRANCH: begin
          br_pend <= 1'b0;
          if (BRANCH_PENALTY > 1) begin
            state     <= FLUSH;
            flush_cnt <= PENALTY_M1;
          end else begin
            state <= RUN;
          end
        end
        ACT_FLUSH: begin
          if (flush_cnt <= 3'd1) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
          end else begin
            state     <= FLUSH;
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        ACT_FREEZE: begin
          state <= FREEZE;
          if (state == RUN && bus.branch_taken) br_pend <= 1'b1;
        end
        default: state <= HOLD;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters: bubbles, flushed IF/ID cycles, frozen cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt     <= 32'd0;
      flush_cnt_tot <= 32'd0;
      freeze_cnt    <= 32'd0;
    end else begin
      if (act == ACT_STALL && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if ((act == ACT_BRANCH || act == ACT_FLUSH) && flush_cnt_tot != 32'hFFFF_FFFF)
        flush_cnt_tot <= flush_cnt_tot + 32'd1;
      if (act == ACT_FREEZE && freeze_cnt != 32'hFFFF_FFFF)
        freeze_cnt <= freeze_cnt + 32'd1;
    end
  end
`endif

endmodule
